// File: rtl/mux_scan_pkg.sv
// Shared constants and FSM state encoding for the 4:1 mux scan sequencer.
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DWELL,
    S_SAMPLE,
    S_HOLD
  } scan_state_t;

endpackage

// File: rtl/scan_dwell_cnt.sv
// Settle-time counter: done is asserted once the current select value has been held SETTLE extra cycles.
module scan_dwell_cnt #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign done = (cnt_q == CNT_W'(SETTLE));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans mux channels 0..3, samples each after a settle time and hands a 4-bit frame downstream.
// Optional frame parity output enabled by defining MUX_SCAN_PARITY_EN.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  output logic [CH_W-1:0]   sel,
  input  logic              mux_in,
  output logic [NUM_CH-1:0] frame_data,
  output logic              frame_valid,
  input  logic              frame_ready,
`ifdef MUX_SCAN_PARITY_EN
  output logic              frame_par,
`endif
  output logic              busy
);

  scan_state_t       state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [NUM_CH-2:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q;
  logic              cnt_clr, cnt_en, cnt_done;

  scan_dwell_cnt #(
    .SETTLE (SETTLE),
    .CNT_W  (CNT_W)
  ) u_dwell_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .done  (cnt_done)
  );

  // Next-state and datapath updates; ch only returns to 0 through IDLE or HOLD.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ch_d = '0;
        if (start) begin
          state_d = S_DWELL;
          cnt_clr = 1'b1;
        end
      end
      S_DWELL: begin
        if (cnt_done) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_SAMPLE: begin
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          data_d  = {mux_in, shadow_q};
          valid_d = 1'b1;
          state_d = S_HOLD;
        end else begin
          shadow_d[ch_q] = mux_in;
          ch_d           = ch_q + CH_W'(1);
          cnt_clr        = 1'b1;
          state_d        = S_DWELL;
        end
      end
      S_HOLD: begin
        if (valid_q && frame_ready) begin
          valid_d = 1'b0;
          ch_d    = '0;
          if (continuous) begin
            state_d = S_DWELL;
            cnt_clr = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= (state_d != S_IDLE);
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  logic par_q;

  // Parity is captured alongside frame_data so it stays aligned through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (state_q == S_SAMPLE && ch_q == CH_W'(NUM_CH - 1)) begin
      par_q <= ^{mux_in, shadow_q};
    end
  end

  assign frame_par = par_q;
`endif

  assign sel         = ch_q;
  assign frame_data  = data_q;
  assign frame_valid = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: expected frames queued at stimulus, compared on handshake.
module tb_mux_scan_ctrl;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned PER    = SETTLE + 2;
  localparam int unsigned FRAME  = 4 * PER;
  localparam int unsigned BOUND  = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic [1:0] sel;
  logic       mux_in;
  logic [3:0] frame_data;
  logic       frame_valid;
  logic       frame_ready = 1'b0;
  logic       busy;
  logic [3:0] chan_in = 4'b0000;
`ifdef MUX_SCAN_PARITY_EN
  logic       frame_par;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  // Board model of the 4:1 mux: sel==n selects input n.
  assign mux_in = chan_in[sel];

  mux_scan_ctrl #(
    .SETTLE (SETTLE),
    .CNT_W  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .continuous  (continuous),
    .sel         (sel),
    .mux_in      (mux_in),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
`ifdef MUX_SCAN_PARITY_EN
    .frame_par   (frame_par),
`endif
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_valid && n < BOUND);
    if (!frame_valid) check({tag, "_timeout"}, 32'(frame_valid), 32'd1);
  endtask

  // Scoreboard: every accepted frame must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && frame_valid && frame_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'(frame_data), 32'hFFFF_FFFF);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("frame_data", 32'(frame_data), 32'(e));
`ifdef MUX_SCAN_PARITY_EN
        check("frame_par", 32'(frame_par), 32'(^e));
`endif
      end
    end
  end

  initial begin
    int n;
    logic [3:0] held;

    // Reset values, then asynchronous reset mid-scan at ch=2.
    tick(2);
    check("rst_valid", 32'(frame_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    chan_in = 4'b1111;
    pulse_start();
    n = 0;
    while (sel != 2'd2 && n < BOUND) begin
      tick();
      n++;
    end
    check("reach_ch2", 32'(sel), 32'd2);
    tick();
    rst_n = 1'b0;
    #1;
    check("async_sel", 32'(sel), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_data", 32'(frame_data), 32'd0);
    check("async_valid", 32'(frame_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(5);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_sel", 32'(sel), 32'd0);
    check("idle_valid", 32'(frame_valid), 32'd0);

    // Single shot: channel stepping, latency and one-cycle valid.
    chan_in = 4'b1101;
    frame_ready = 1'b1;
    exp_q.push_back(4'b1101);
    pulse_start();
    for (int e = 0; e < int'(FRAME); e++) begin
      check($sformatf("ss_sel_e%0d", e), 32'(sel), 32'(e / int'(PER)));
      check($sformatf("ss_busy_e%0d", e), 32'(busy), 32'd1);
      check($sformatf("ss_novalid_e%0d", e), 32'(frame_valid), 32'd0);
      tick();
    end
    check("ss_valid", 32'(frame_valid), 32'd1);
    tick();
    check("ss_valid_drop", 32'(frame_valid), 32'd0);
    check("ss_busy_drop", 32'(busy), 32'd0);
    check("ss_sel_idle", 32'(sel), 32'd0);

    // Backpressure: HOLD keeps everything stable and ignores start.
    frame_ready = 1'b0;
    chan_in = 4'b0110;
    exp_q.push_back(4'b0110);
    held = 4'b0110;
    pulse_start();
    wait_valid("bp", n);
    check("bp_latency", 32'(n), 32'(FRAME));
    for (int c = 0; c < 10; c++) begin
      start = c[0];
      check("bp_valid", 32'(frame_valid), 32'd1);
      check("bp_sel", 32'(sel), 32'd3);
      check("bp_data", 32'(frame_data), 32'(held));
      tick();
    end
    start = 1'b0;
    frame_ready = 1'b1;
    tick();
    check("bp_accept", 32'(frame_valid), 32'd0);
    check("bp_idle", 32'(busy), 32'd0);
    tick(3);
    check("bp_stay_idle", 32'(busy), 32'd0);

    // Continuous: frames every FRAME+1 cycles, then stop after dropping continuous.
    continuous = 1'b1;
    chan_in = 4'b1001;
    exp_q.push_back(4'b1001);
    pulse_start();
    wait_valid("c1", n);
    check("c1_latency", 32'(n), 32'(FRAME));
    chan_in = 4'b0110;
    exp_q.push_back(4'b0110);
    wait_valid("c2", n);
    check("c2_period", 32'(n), 32'(FRAME + 1));
    chan_in = 4'b1101;
    exp_q.push_back(4'b1101);
    tick(5);
    check("c3_busy", 32'(busy), 32'd1);
    continuous = 1'b0;
    wait_valid("c3", n);
    check("c3_period", 32'(n + 5), 32'(FRAME + 1));
    tick();
    check("c3_valid_drop", 32'(frame_valid), 32'd0);
    check("c3_idle", 32'(busy), 32'd0);
    tick(2 * FRAME);
    check("c_no_more_busy", 32'(busy), 32'd0);
    check("c_no_more_valid", 32'(frame_valid), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
